spi_slave_ram_ctrl: RTL and testbench
=====================================

// Module: spi_slave_ram_ctrl
// PURPOSE
//  SPI slave front-end that sequences the SPI RAM. Deserialises MOSI frames into
//  {cmd[1:0],payload[7:0]} words, presents each as a one-cycle rx_valid to the RAM,
//  waits for the RAM read response and serialises it back on MISO.
//  Sits between the SPI pins and the RAM inside the SPI wrapper.
// PARAMETERS
//  ADDR_SIZE   8   payload / RAM word width; frame width FRAME_W = ADDR_SIZE+2
//  TX_TIMEOUT  15  clk cycles WAIT_TX waits for tx_valid before abandoning the read
// PORTS
//  clk       in   1          SPI clock; all logic on posedge
//  rst       in   1          asynchronous, active-high reset
//  ss_n      in   1          slave select, active low; frame = contiguous low period
//  mosi      in   1          serial data in, MSB first, sampled on posedge clk
//  miso      out  1          serial data out, MSB first, registered
//  rx_data   out  FRAME_W    assembled frame to RAM: [9:8] cmd, [7:0] addr/data
//  rx_valid  out  1          one-cycle strobe: rx_data valid
//  tx_data   in   ADDR_SIZE  RAM read data
//  tx_valid  in   1          RAM read data valid (single-cycle pulse)
// BEHAVIOUR
//  Reset: state=IDLE, miso=0, rx_data=0, rx_valid=0, bit_cnt=0, rd_addr_seen=0.
//  All outputs registered. Cmds: 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
//  States:
//   IDLE:      ss_n=0 -> CHK_CMD (no bit sampled this cycle).
//   CHK_CMD:   sample mosi as frame bit FRAME_W-1 into shreg; bit_cnt=1;
//              mosi=0 -> WRITE; mosi=1 & !rd_addr_seen -> READ_ADD;
//              mosi=1 & rd_addr_seen -> READ_DATA.
//   WRITE/READ_ADD/READ_DATA: shift one mosi bit per clk; after bit FRAME_W
//              (bit_cnt==FRAME_W-1 sampled) rx_data<=frame, rx_valid=1 next cycle.
//              WRITE, READ_ADD -> DONE; READ_ADD sets rd_addr_seen.
//              READ_DATA -> WAIT_TX; clears rd_addr_seen.
//   WAIT_TX:   tx_valid=1 -> latch tx_data, -> SHIFT_OUT; tmo counter incr each
//              cycle; tmo==TX_TIMEOUT -> DONE, miso stays 0.
//   SHIFT_OUT: miso = latched bit ADDR_SIZE-1 on first cycle after latch, then
//              one bit per clk down to bit 0 (ADDR_SIZE cycles) -> DONE.
//   DONE:      miso=0, ignore mosi; ss_n=1 -> IDLE.
//  rx_valid high exactly one cycle per complete frame; never for partial frames.
//  Second bit decides 00/01 or 10/11 only inside rx_data; ctrl does not re-check it
//  except rd_addr_seen bookkeeping above (rd-data frame while flag=0 is sent as
//  read-address frame: cmd bits forwarded as received).
//  Boundaries:
//   ss_n=1 in any non-IDLE state -> IDLE next cycle; partial frame discarded,
//     no rx_valid, miso=0, bit_cnt/tmo cleared, rd_addr_seen unchanged.
//   ss_n=1 same cycle as last frame bit: frame discarded (ss_n wins).
//   Extra mosi bits after frame end: ignored until ss_n rises.
//   tx_valid outside WAIT_TX: ignored.
//   rst mid-frame: immediate return to reset values, incl. rd_addr_seen=0.
// STRUCTURE
//  Package spi_ram_ctrl_pkg: state enum (8 states), CMD_* constants, FRAME_W fn.
//  One sub-module: spi_tx_serializer (load/tx_data latch, ADDR_SIZE-bit MSB-first
//  shifter, done flag). Deserialiser, bit_cnt, tmo counter and FSM stay top-level.
// TESTING
//  1 Write: frame 00_0x2A then 01_0x5C -> two rx_valid pulses, rx_data 0x02A, 0x15C;
//    miso stays 0.
//  2 Read: frame 10_0x2A, then 11_0x00; drive tx_valid+tx_data=0x5C 1 cycle after
//    rx_valid -> miso 0,1,0,1,1,1,0,0 on 8 consecutive cycles; rd_addr_seen 1->0.
//  3 Abort: raise ss_n after 6 bits of write frame -> no rx_valid, IDLE next cycle;
//    following full frame accepted normally.
//  4 Flag order: 11_0x00 with rd_addr_seen=0 -> rx_data 0x300, goes READ_ADD path,
//    rd_addr_seen=1, no MISO shifting.
//  5 Timeout: rd-data frame, no tx_valid -> DONE after 15 cycles, miso 0; late
//    tx_valid ignored.
//  6 Reset: assert rst during SHIFT_OUT bit 3 -> miso=0, IDLE, rd_addr_seen=0
//    same cycle (async).

Source files
------------

// File: rtl/spi_ram_ctrl_pkg.sv
// Shared types and constants for the SPI slave RAM controller.
package spi_ram_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHK_CMD,
      ST_WRITE,
      ST_READ_ADD,
      ST_READ_DATA,
      ST_WAIT_TX,
      ST_SHIFT_OUT,
      ST_DONE
   } state_t;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   function automatic int frame_w(input int addr_size);
      return addr_size + 2;
   endfunction

endpackage

// File: rtl/spi_tx_serializer.sv
// Latches one RAM read word and shifts it out MSB first on a registered miso.
module spi_tx_serializer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         miso,
   output logic         done
);

   localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

   logic [W-1:0]     shreg_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             miso_reg;

   // miso is forced low whenever the controller is not actively shifting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg_reg <= '0;
         cnt_reg   <= '0;
         miso_reg  <= 1'b0;
      end else if (load) begin
         shreg_reg <= din;
         cnt_reg   <= '0;
         miso_reg  <= 1'b0;
      end else if (shift) begin
         miso_reg  <= shreg_reg[W-1];
         shreg_reg <= {shreg_reg[W-2:0], 1'b0};
         cnt_reg   <= cnt_reg + 1'b1;
      end else begin
         miso_reg  <= 1'b0;
      end
   end

   assign miso = miso_reg;
   assign done = shift && (cnt_reg == LAST);

endmodule

// File: rtl/spi_slave_ram_ctrl.sv
// SPI slave front-end: deserialises MOSI frames for the RAM and serialises
// the RAM read response back onto MISO.
module spi_slave_ram_ctrl
   import spi_ram_ctrl_pkg::*;
#(
   parameter int ADDR_SIZE  = 8,
   parameter int TX_TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ss_n,
   input  logic                 mosi,
   output logic                 miso,
   output logic [ADDR_SIZE+1:0] rx_data,
   output logic                 rx_valid,
   input  logic [ADDR_SIZE-1:0] tx_data,
   input  logic                 tx_valid
);

   localparam int FRAME_W = frame_w(ADDR_SIZE);
   localparam int CNT_W   = $clog2(FRAME_W);
   localparam int TMO_W   = $clog2(TX_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TX_TIMEOUT - 1);

   state_t               state_reg, state_next;
   logic [CNT_W-1:0]     bit_cnt_reg, bit_cnt_next;
   logic [TMO_W-1:0]     tmo_reg, tmo_next;
   logic [FRAME_W-1:0]   shreg_reg, shreg_next;
   logic [FRAME_W-1:0]   rx_data_reg, rx_data_next;
   logic                 rx_valid_reg, rx_valid_next;
   logic                 rd_addr_seen_reg, rd_addr_seen_next;
   logic [FRAME_W-1:0]   frame;
   logic                 ser_load, ser_shift, ser_done;

   assign frame = {shreg_reg[FRAME_W-2:0], mosi};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg        <= ST_IDLE;
         bit_cnt_reg      <= '0;
         tmo_reg          <= '0;
         shreg_reg        <= '0;
         rx_data_reg      <= '0;
         rx_valid_reg     <= 1'b0;
         rd_addr_seen_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         bit_cnt_reg      <= bit_cnt_next;
         tmo_reg          <= tmo_next;
         shreg_reg        <= shreg_next;
         rx_data_reg      <= rx_data_next;
         rx_valid_reg     <= rx_valid_next;
         rd_addr_seen_reg <= rd_addr_seen_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      bit_cnt_next      = bit_cnt_reg;
      tmo_next          = tmo_reg;
      shreg_next        = shreg_reg;
      rx_data_next      = rx_data_reg;
      rx_valid_next     = 1'b0;
      rd_addr_seen_next = rd_addr_seen_reg;
      ser_load          = 1'b0;
      ser_shift         = 1'b0;

      // Deselect wins over everything, including the last bit of a frame
      if (state_reg != ST_IDLE && ss_n) begin
         state_next   = ST_IDLE;
         bit_cnt_next = '0;
         tmo_next     = '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               bit_cnt_next = '0;
               tmo_next     = '0;
               if (!ss_n)
                  state_next = ST_CHK_CMD;
            end
            ST_CHK_CMD: begin
               shreg_next   = {{(FRAME_W-1){1'b0}}, mosi};
               bit_cnt_next = CNT_W'(1);
               if (mosi == CMD_WR_ADDR[1])
                  state_next = ST_WRITE;
               else if (rd_addr_seen_reg)
                  state_next = ST_READ_DATA;
               else
                  state_next = ST_READ_ADD;
            end
            ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
               shreg_next = frame;
               if (bit_cnt_reg == LAST_BIT) begin
                  rx_data_next  = frame;
                  rx_valid_next = 1'b1;
                  bit_cnt_next  = '0;
                  if (state_reg == ST_READ_DATA) begin
                     rd_addr_seen_next = 1'b0;
                     tmo_next          = '0;
                     state_next        = ST_WAIT_TX;
                  end else begin
                     if (state_reg == ST_READ_ADD)
                        rd_addr_seen_next = 1'b1;
                     state_next = ST_DONE;
                  end
               end else begin
                  bit_cnt_next = bit_cnt_reg + 1'b1;
               end
            end
            ST_WAIT_TX: begin
               if (tx_valid) begin
                  ser_load   = 1'b1;
                  tmo_next   = '0;
                  state_next = ST_SHIFT_OUT;
               end else if (tmo_reg == TMO_LAST) begin
                  tmo_next   = '0;
                  state_next = ST_DONE;
               end else begin
                  tmo_next = tmo_reg + 1'b1;
               end
            end
            ST_SHIFT_OUT: begin
               ser_shift = 1'b1;
               if (ser_done)
                  state_next = ST_DONE;
            end
            ST_DONE: begin
               state_next = ST_DONE;
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   spi_tx_serializer #(
      .W(ADDR_SIZE)
   ) u_tx_serializer (
      .clk   (clk),
      .rst   (rst),
      .load  (ser_load),
      .shift (ser_shift),
      .din   (tx_data),
      .miso  (miso),
      .done  (ser_done)
   );

   assign rx_data  = rx_data_reg;
   assign rx_valid = rx_valid_reg;

endmodule

// File: tb/tb_spi_slave_ram_ctrl.sv
// Randomised self-checking bench for spi_slave_ram_ctrl against a frame-level model.
module tb_spi_slave_ram_ctrl;
   import spi_ram_ctrl_pkg::*;

   localparam int ADDR_SIZE  = 8;
   localparam int FRAME_W    = ADDR_SIZE + 2;
   localparam int TX_TIMEOUT = 15;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 ss_n;
   logic                 mosi;
   logic                 miso;
   logic [FRAME_W-1:0]   rx_data;
   logic                 rx_valid;
   logic [ADDR_SIZE-1:0] tx_data;
   logic                 tx_valid;

   int tests_run    = 0;
   int tests_failed = 0;
   int miso_hi_cnt  = 0;
   bit model_seen   = 1'b0;
   logic [FRAME_W-1:0] rx_q[$];

   spi_slave_ram_ctrl #(
      .ADDR_SIZE  (ADDR_SIZE),
      .TX_TIMEOUT (TX_TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ss_n     (ss_n),
      .mosi     (mosi),
      .miso     (miso),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid)
   );

   always #5 clk = ~clk;

   // Monitors sample on negedge; stimulus and checks run 1 time unit later
   always @(negedge clk) begin
      if (rst === 1'b0 && rx_valid === 1'b1)
         rx_q.push_back(rx_data);
      if (miso !== 1'b0)
         miso_hi_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   // Select the slave and shift nbits of the frame MSB first; ss_n is left low
   task automatic send_bits(input logic [FRAME_W-1:0] f, input int nbits);
      ss_n = 1'b0;
      tick();
      for (int i = 0; i < nbits; i++) begin
         mosi = f[FRAME_W-1-i];
         tick();
      end
   endtask

   task automatic end_frame();
      ss_n = 1'b1;
      mosi = 1'b0;
      tick(2);
   endtask

   // Frame-level model: returns 1 when the frame is a read-data request that
   // will wait for RAM data (cmd MSB set and a read address already seen)
   function automatic bit model_frame(input logic [FRAME_W-1:0] f);
      bit rd = 1'b0;
      if (f[FRAME_W-1]) begin
         if (model_seen) begin
            rd         = 1'b1;
            model_seen = 1'b0;
         end else begin
            model_seen = 1'b1;
         end
      end
      return rd;
   endfunction

   function automatic logic [FRAME_W-1:0] first_rx();
      return (rx_q.size() > 0) ? rx_q[0] : 'x;
   endfunction

   task automatic test_reset();
      rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
      tick(3);
      tests_run++;
      if (miso !== 1'b0) begin
         tests_failed++; $display("FAIL reset_miso: got %b expected 0", miso);
      end
      tests_run++;
      if (rx_valid !== 1'b0) begin
         tests_failed++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid);
      end
      tests_run++;
      if (rx_data !== '0) begin
         tests_failed++; $display("FAIL reset_rx_data: got %h expected 000", rx_data);
      end
      rst = 1'b0;
      model_seen = 1'b0;
      tick(2);
   endtask

   task automatic test_write();
      logic [FRAME_W-1:0] f;
      for (int t = 0; t < 8; t++) begin
         if (t == 0)      f = {CMD_WR_ADDR, 8'h2A};
         else if (t == 1) f = {CMD_WR_DATA, 8'h5C};
         else             f = {1'b0, 1'($urandom), ADDR_SIZE'($urandom)};
         rx_q.delete(); miso_hi_cnt = 0;
         send_bits(f, FRAME_W);
         void'(model_frame(f));
         end_frame();
         tests_run++;
         if (rx_q.size() != 1 || rx_q[0] !== f) begin
            tests_failed++;
            $display("FAIL write_rx[%0d]: got %0d frames first %h, expected 1 frame %h",
                     t, rx_q.size(), first_rx(), f);
         end
         tests_run++;
         if (miso_hi_cnt != 0) begin
            tests_failed++;
            $display("FAIL write_miso[%0d]: got %0d high cycles expected 0", t, miso_hi_cnt);
         end
      end
   endtask

   task automatic test_read();
      logic [FRAME_W-1:0]   fa, fd;
      logic [ADDR_SIZE-1:0] data;
      int dly;
      bit w;
      logic exp_bit;
      for (int t = 0; t < 5; t++) begin
         if (t == 0) begin
            fa = {CMD_RD_ADDR, 8'h2A}; fd = {CMD_RD_DATA, 8'h00}; data = 8'h5C; dly = 1;
         end else begin
            fa   = {1'b1, 1'($urandom), ADDR_SIZE'($urandom)};
            fd   = {1'b1, 1'($urandom), ADDR_SIZE'($urandom)};
            data = ADDR_SIZE'($urandom);
            dly  = $urandom_range(0, 10);
         end
         rx_q.delete();
         send_bits(fa, FRAME_W);
         void'(model_frame(fa));
         end_frame();
         send_bits(fd, FRAME_W);
         w = model_frame(fd);
         tests_run++;
         if (rx_q.size() != 2 || rx_q[0] !== fa || rx_q[1] !== fd) begin
            tests_failed++;
            $display("FAIL read_rx[%0d]: got %0d frames first %h, expected %h then %h",
                     t, rx_q.size(), first_rx(), fa, fd);
         end
         repeat (dly) tick();
         tx_data = data; tx_valid = 1'b1;
         tick();
         tx_valid = 1'b0; tx_data = ADDR_SIZE'($urandom);
         for (int b = ADDR_SIZE - 1; b >= 0; b--) begin
            tick();
            exp_bit = (w && dly < TX_TIMEOUT) ? data[b] : 1'b0;
            tests_run++;
            if (miso !== exp_bit) begin
               tests_failed++;
               $display("FAIL read_miso[%0d] bit %0d: got %b expected %b", t, b, miso, exp_bit);
            end
         end
         tick();
         tests_run++;
         if (miso !== 1'b0) begin
            tests_failed++; $display("FAIL read_miso_done[%0d]: got %b expected 0", t, miso);
         end
         end_frame();
      end
   endtask

   task automatic test_abort();
      logic [FRAME_W-1:0]   f, fa;
      logic [ADDR_SIZE-1:0] data;
      bit w;
      // Partial write frame followed immediately by a full one
      f = {CMD_WR_DATA, ADDR_SIZE'($urandom)};
      rx_q.delete();
      send_bits({CMD_WR_ADDR, ADDR_SIZE'($urandom)}, 6);
      ss_n = 1'b1;
      tick();
      send_bits(f, FRAME_W);
      void'(model_frame(f));
      end_frame();
      tests_run++;
      if (rx_q.size() != 1 || rx_q[0] !== f) begin
         tests_failed++;
         $display("FAIL abort_partial: got %0d frames first %h, expected 1 frame %h",
                  rx_q.size(), first_rx(), f);
      end
      // Deselect on the very last bit discards the frame
      rx_q.delete();
      f = {CMD_WR_ADDR, ADDR_SIZE'($urandom)};
      send_bits(f, FRAME_W - 1);
      mosi = f[0]; ss_n = 1'b1;
      tick(3);
      tests_run++;
      if (rx_q.size() != 0) begin
         tests_failed++;
         $display("FAIL abort_last_bit: got %0d frames expected 0", rx_q.size());
      end
      // Trailing bits after a complete frame are ignored
      rx_q.delete(); miso_hi_cnt = 0;
      f = {CMD_WR_DATA, ADDR_SIZE'($urandom)};
      send_bits(f, FRAME_W);
      void'(model_frame(f));
      for (int i = 0; i < 14; i++) begin
         mosi = 1'($urandom);
         tick();
      end
      end_frame();
      tests_run++;
      if (rx_q.size() != 1 || rx_q[0] !== f || miso_hi_cnt != 0) begin
         tests_failed++;
         $display("FAIL abort_extra_bits: got %0d frames first %h miso_hi %0d, expected 1 frame %h miso_hi 0",
                  rx_q.size(), first_rx(), miso_hi_cnt, f);
      end
      // Aborted read-data frame must not consume the read-address flag
      fa = {CMD_RD_ADDR, ADDR_SIZE'($urandom)};
      send_bits(fa, FRAME_W);
      void'(model_frame(fa));
      end_frame();
      send_bits({CMD_RD_DATA, ADDR_SIZE'($urandom)}, 5);
      end_frame();
      rx_q.delete(); miso_hi_cnt = 0;
      f    = {CMD_RD_DATA, ADDR_SIZE'($urandom)};
      data = ADDR_SIZE'($urandom);
      send_bits(f, FRAME_W);
      w = model_frame(f);
      tx_data = data; tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      tick(ADDR_SIZE + 3);
      end_frame();
      tests_run++;
      if (miso_hi_cnt != (w ? $countones(data) : 0)) begin
         tests_failed++;
         $display("FAIL abort_keeps_flag: got %0d miso high cycles expected %0d",
                  miso_hi_cnt, w ? $countones(data) : 0);
      end
   endtask

   task automatic test_flag_order();
      logic [FRAME_W-1:0] f;
      bit w;
      f = {CMD_RD_DATA, 8'h00};
      rx_q.delete(); miso_hi_cnt = 0;
      send_bits(f, FRAME_W);
      w = model_frame(f);
      tx_data = 8'hFF; tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      tick(12);
      end_frame();
      tests_run++;
      if (rx_q.size() != 1 || rx_q[0] !== 10'h300) begin
         tests_failed++;
         $display("FAIL flag_order_rx: got %0d frames first %h, expected 1 frame 300",
                  rx_q.size(), first_rx());
      end
      tests_run++;
      if (miso_hi_cnt != (w ? 8 : 0)) begin
         tests_failed++;
         $display("FAIL flag_order_miso: got %0d high cycles expected %0d", miso_hi_cnt, w ? 8 : 0);
      end
   endtask

   task automatic test_timeout();
      logic [FRAME_W-1:0] f;
      int dly;
      bit w;
      if (!model_seen) begin
         f = {CMD_RD_ADDR, ADDR_SIZE'($urandom)};
         send_bits(f, FRAME_W);
         void'(model_frame(f));
         end_frame();
      end
      f = {CMD_RD_DATA, ADDR_SIZE'($urandom)};
      dly = TX_TIMEOUT + 4;
      rx_q.delete(); miso_hi_cnt = 0;
      send_bits(f, FRAME_W);
      w = model_frame(f);
      tick(dly);
      tx_data = 8'hFF; tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      tick(12);
      end_frame();
      tests_run++;
      if (rx_q.size() != 1 || rx_q[0] !== f) begin
         tests_failed++;
         $display("FAIL timeout_rx: got %0d frames first %h, expected 1 frame %h",
                  rx_q.size(), first_rx(), f);
      end
      tests_run++;
      if (miso_hi_cnt != ((w && dly < TX_TIMEOUT) ? 8 : 0)) begin
         tests_failed++;
         $display("FAIL timeout_late_tx: got %0d miso high cycles expected %0d",
                  miso_hi_cnt, (w && dly < TX_TIMEOUT) ? 8 : 0);
      end
   endtask

   task automatic test_reset_mid();
      logic [FRAME_W-1:0] f;
      logic [ADDR_SIZE-1:0] data;
      bit w;
      if (!model_seen) begin
         f = {CMD_RD_ADDR, ADDR_SIZE'($urandom)};
         send_bits(f, FRAME_W);
         void'(model_frame(f));
         end_frame();
      end
      f = {CMD_RD_DATA, ADDR_SIZE'($urandom)};
      data = 8'h5C;
      send_bits(f, FRAME_W);
      w = model_frame(f);
      tx_data = data; tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      tick(5);
      tests_run++;
      if (miso !== (w ? data[3] : 1'b0)) begin
         tests_failed++;
         $display("FAIL reset_mid_bit3: got %b expected %b", miso, w ? data[3] : 1'b0);
      end
      #1 rst = 1'b1;
      #1;
      tests_run++;
      if (miso !== 1'b0 || rx_valid !== 1'b0 || rx_data !== '0) begin
         tests_failed++;
         $display("FAIL reset_mid_async: got miso %b rx_valid %b rx_data %h, expected 0 0 000",
                  miso, rx_valid, rx_data);
      end
      ss_n = 1'b1; mosi = 1'b0;
      tick();
      rst = 1'b0;
      model_seen = 1'b0;
      tick();
      // With the flag cleared, a read-data frame takes the read-address path
      rx_q.delete(); miso_hi_cnt = 0;
      f = {CMD_RD_DATA, ADDR_SIZE'($urandom)};
      send_bits(f, FRAME_W);
      w = model_frame(f);
      tx_data = 8'hFF; tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      tick(12);
      end_frame();
      tests_run++;
      if (rx_q.size() != 1 || rx_q[0] !== f || miso_hi_cnt != (w ? 8 : 0)) begin
         tests_failed++;
         $display("FAIL reset_mid_flag: got %0d frames first %h miso_hi %0d, expected 1 frame %h miso_hi %0d",
                  rx_q.size(), first_rx(), miso_hi_cnt, f, w ? 8 : 0);
      end
   endtask

   task automatic test_back_to_back();
      logic [FRAME_W-1:0] f;
      logic [FRAME_W-1:0] exp_q[$];
      rx_q.delete();
      for (int t = 0; t < 6; t++) begin
         f = {1'b0, 1'($urandom), ADDR_SIZE'($urandom)};
         exp_q.push_back(f);
         send_bits(f, FRAME_W);
         void'(model_frame(f));
         ss_n = 1'b1;
         tick();
      end
      tick(2);
      tests_run++;
      if (rx_q.size() != exp_q.size()) begin
         tests_failed++;
         $display("FAIL b2b_count: got %0d frames expected %0d", rx_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (rx_q[i] !== exp_q[i]) begin
               tests_failed++;
               $display("FAIL b2b_frame[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_abort();
      test_flag_order();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
